// File: rtl/key_arbiter_if.sv
// key_arbiter_if: grant handshake between key_arbiter and a downstream consumer.
//   gnt_valid  master->slave  a grant is presented
//   gnt_code   master->slave  code of the granted key (key n -> 3-n)
//   gnt_ready  slave->master  consumer accepts the current grant
interface key_arbiter_if;
  logic       gnt_valid;
  logic       gnt_ready;
  logic [1:0] gnt_code;
  modport master (output gnt_valid, output gnt_code, input gnt_ready);
  modport slave  (input gnt_valid, input gnt_code, output gnt_ready);
endinterface

// File: rtl/key_arbiter.sv
// key_arbiter: debounces four active-low push-buttons and grants one queued press at a time.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   key_i  raw buttons, active-low, asynchronous to clk
//   gnt    grant handshake (master side): gnt_valid/gnt_code out, gnt_ready in
//   pend_o pending-request bits, bit n = key n
//   led_o  code of the last accepted grant
// Build option: KEY_ARBITER_ROUND_ROBIN_EN selects round-robin arbitration
// (search starts after the last granted key); otherwise KEY[3] has fixed top priority.
module key_arbiter #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    key_i,
  key_arbiter_if.master gnt,
  output logic [3:0]    pend_o,
  output logic [1:0]    led_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t               state_q, state_d;
  logic [3:0]           sync1_q, p_q, s_q, s_d, s_prev_q, pend_q, pend_d, press;
  logic [3:0][CW-1:0]   cnt_q, cnt_d;
  logic [1:0]           code_q, code_d, led_q, led_d, w;
  logic                 accept;

  assign press         = s_q & ~s_prev_q;
  assign accept        = (state_q == GRANT) && gnt.gnt_ready;
  assign gnt.gnt_valid = state_q == GRANT;
  assign gnt.gnt_code  = code_q;
  assign pend_o        = pend_q;
  assign led_o         = led_q;

`ifdef KEY_ARBITER_ROUND_ROBIN_EN
  logic [1:0] ptr_q;
  // Descending scan so the pending key closest after the pointer is assigned last.
  always_comb begin
    w = ptr_q;
    for (int i = 4; i >= 1; i--)
      if (pend_q[2'(ptr_q + i)]) w = 2'(ptr_q + i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= '0;
    else if (accept) ptr_q <= ~code_q;
`else
  always_comb begin
    w = '0;
    for (int i = 0; i < 4; i++)
      if (pend_q[i]) w = 2'(i);
  end
`endif

  // The code of key n is 3-n, which for two bits is simply ~n, so the held
  // code doubles as the captured winner.
  always_comb begin
    s_d     = s_q;
    cnt_d   = '0;
    pend_d  = pend_q;
    state_d = state_q;
    code_d  = code_q;
    led_d   = led_q;
    for (int i = 0; i < 4; i++)
      if (p_q[i] != s_q[i]) begin
        if (cnt_q[i] == CNT_MAX) s_d[i] = ~s_q[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    if (accept) begin
      pend_d[~code_q] = 1'b0;
      led_d           = code_q;
      state_d         = IDLE;
    end
    pend_d = pend_d | press;
    if (state_q == IDLE && |pend_q) begin
      state_d = GRANT;
      code_d  = ~w;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      sync1_q  <= '0;
      p_q      <= '0;
      s_q      <= '0;
      s_prev_q <= '0;
      cnt_q    <= '0;
      pend_q   <= '0;
      code_q   <= 2'b11;
      led_q    <= 2'b11;
    end else begin
      state_q  <= state_d;
      sync1_q  <= ~key_i;
      p_q      <= sync1_q;
      s_q      <= s_d;
      s_prev_q <= s_q;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      code_q   <= code_d;
      led_q    <= led_d;
    end
endmodule

// File: tb/tb_key_arbiter.sv
// tb_key_arbiter: randomized scoreboard bench for key_arbiter with a behavioural reference model.
module tb_key_arbiter;
  localparam int DC = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] key = 4'hF;
  logic [3:0] pend;
  logic [1:0] led;
  key_arbiter_if gif();
  key_arbiter #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .key_i(key), .gnt(gif), .pend_o(pend), .led_o(led));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  logic [3:0] sched [0:16383];
  logic [1:0] exp_q [$];
  logic [3:0] m_pend, m_old, m_ev;
  logic       m_busy;
  logic [1:0] m_code, m_led;
  int         m_w, m_ptr;
  int         st [4], ln [4];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int ptr);
`ifdef KEY_ARBITER_ROUND_ROBIN_EN
    for (int i = 1; i <= 4; i++) if (r[(ptr + i) % 4]) return (ptr + i) % 4;
`else
    for (int i = 3; i >= 0; i--) if (r[i]) return i;
`endif
    return 0;
  endfunction

  // Reference model: a press registers 7 cycles after the key falls; one
  // grant at a time, an idle cycle between grants.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = '0; m_busy = 1'b0; m_code = 2'b11; m_led = 2'b11; m_ptr = 0; m_w = 0;
      exp_q.delete();
    end else begin
      cyc++;
      m_ev = sched[cyc];
      m_old = m_pend;
      if (m_busy) begin
        if (gif.gnt_ready) begin
          m_pend[m_w] = 1'b0; m_led = m_code; m_ptr = m_w; m_busy = 1'b0;
        end
      end else if (m_old != 4'h0) begin
        m_w = pick(m_old, m_ptr);
        m_code = 2'(3 - m_w);
        m_busy = 1'b1;
        exp_q.push_back(m_code);
      end
      m_pend = m_pend | m_ev;
    end
  end

  // Monitor: level checks every cycle, scoreboard pop on each handshake.
  always @(negedge clk) if (rst_n) begin
    chk("gnt_valid", int'(gif.gnt_valid), int'(m_busy));
    chk("pend", int'(pend), int'(m_pend));
    chk("led", int'(led), int'(m_led));
    chk("gnt_code_hold", int'(gif.gnt_code), int'(m_code));
    if (gif.gnt_valid && gif.gnt_ready) begin
      if (exp_q.size() == 0) chk("unexpected_grant", int'(gif.gnt_code), -1);
      else chk("grant_code", int'(gif.gnt_code), int'(exp_q.pop_front()));
    end
  end

  task automatic clear_keys();
    for (int k = 0; k < 4; k++) begin st[k] = 0; ln[k] = 0; end
  endtask

  // mode: 0 random ready, 1 ready high, 2 ready low
  task automatic run(input int ncyc, input int mode);
    logic [3:0] prev, cur;
    prev = 4'h0;
    for (int t = 0; t < ncyc; t++) begin
      @(posedge clk); #1;
      cur = 4'h0;
      for (int k = 0; k < 4; k++)
        if (ln[k] > 0 && t >= st[k] && t < st[k] + ln[k]) cur[k] = 1'b1;
      for (int k = 0; k < 4; k++)
        if (cur[k] && !prev[k] && ln[k] >= DC) sched[cyc + 7][k] = 1'b1;
      key = ~cur;
      gif.gnt_ready = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : ($urandom_range(0, 2) != 0);
      prev = cur;
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) sched[i] = 4'h0;
    gif.gnt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(gif.gnt_valid), 0);
    chk("rst_code", int'(gif.gnt_code), 3);
    chk("rst_led", int'(led), 3);
    chk("rst_pend", int'(pend), 0);
    rst_n = 1'b1;
    clear_keys(); run(6, 1);
    clear_keys(); ln[2] = 20; run(40, 1);
    clear_keys(); ln[1] = 2; run(20, 1);
    clear_keys(); ln[0] = 8; ln[3] = 8; run(20, 2);
    clear_keys(); run(20, 1);
    clear_keys(); for (int k = 0; k < 4; k++) ln[k] = 8; run(30, 1);
    for (int r = 0; r < 40; r++) begin
      clear_keys();
      for (int k = 0; k < 4; k++) begin
        int kind;
        kind = $urandom_range(0, 3);
        st[k] = $urandom_range(0, 4);
        ln[k] = kind == 0 ? 0 : kind == 2 ? $urandom_range(1, 3) : $urandom_range(6, 10);
      end
      run(32, r % 5 == 4 ? 2 : 0);
    end
    clear_keys(); run(20, 1);
    clear_keys(); ln[1] = 8; run(30, 2);
    chk("pre_rst_valid", int'(gif.gnt_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(gif.gnt_valid), 0);
    chk("mid_rst_pend", int'(pend), 0);
    chk("mid_rst_led", int'(led), 3);
    chk("mid_rst_code", int'(gif.gnt_code), 3);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_keys(); run(20, 1);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
